// File: rtl/config_frame_pkg.sv
// Shared definitions for the configuration frame writer.
//   state_t            : writer FSM states
//   SYNC_WORD_DEFAULT  : stream synchronisation word
//   HDR_*              : header word field positions (col, start frame, count)
//   onehot_bit()       : single-bit one-hot decode helper
package config_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    HEADER,
    DATA,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

  localparam int unsigned HDR_COL_MSB = 31;
  localparam int unsigned HDR_COL_LSB = 24;
  localparam int unsigned HDR_FRM_MSB = 20;
  localparam int unsigned HDR_FRM_LSB = 16;
  localparam int unsigned HDR_CNT_MSB = 15;
  localparam int unsigned HDR_CNT_LSB = 0;

  // True when bit 'pos' of onehot(idx) is set.
  function automatic logic onehot_bit(input logic [7:0] idx, input int unsigned pos);
    return 32'(idx) == pos;
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered index -> one-hot decoder.
//   clk, rst  : clock, async active-high reset (output clears immediately)
//   load      : capture onehot(idx) on next edge (has priority over clear)
//   clear     : drive output to zero on next edge
//   idx       : bit index to decode
//   onehot_q  : registered one-hot output; otherwise holds its value
module frame_strobe_decoder
  import config_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot_q
);

  logic [WIDTH-1:0] onehot_d;

  always_comb begin
    onehot_d = onehot_q;
    if (load) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        onehot_d[i] = onehot_bit(8'(idx), i);
      end
    end else if (clear) begin
      onehot_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) onehot_q <= '0;
    else     onehot_q <= onehot_d;
  end

endmodule

// File: rtl/config_frame_writer.sv
// Fabric configuration writer: hunts a sync word in a valid/ready 32-bit
// bitstream, decodes header words and writes each data word to one frame of
// one column with a one-cycle one-hot FrameStrobe (SETUP/STROBE/HOLD framing).
//   CLK, reset   : clock, async active-high reset
//   s_data/s_valid/s_ready : bitstream input handshake
//   FrameData    : frame data to column bus (changes only on data accept)
//   FrameStrobe  : one-hot frame write pulse
//   ColSelect    : one-hot column select qualifying FrameStrobe
//   ConfigDone   : sticky, end-of-stream header seen
//   ConfigErr    : sticky, illegal header or frame overrun
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 32,
  parameter int unsigned NumColumns      = 16,
  parameter logic [31:0] SYNC_WORD       = SYNC_WORD_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumColumns-1:0]      ColSelect,
  output logic                       ConfigDone,
  output logic                       ConfigErr
);

  localparam int unsigned FRM_W = $clog2(MaxFramesPerCol) + 1;

  state_t                     state_q, state_d;
  logic [7:0]                 col_q, col_d;
  logic [FRM_W-1:0]           frame_q, frame_d;
  logic [15:0]                remaining_q, remaining_d;
  logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
  logic                       s_ready_q, s_ready_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic       xfer;
  logic       col_load, col_clear, strobe_load;
  logic [7:0] hdr_col;
  logic [4:0] hdr_frm;
  logic [15:0] hdr_cnt;

  assign xfer    = s_valid && s_ready_q;
  assign hdr_col = s_data[HDR_COL_MSB:HDR_COL_LSB];
  assign hdr_frm = s_data[HDR_FRM_MSB:HDR_FRM_LSB];
  assign hdr_cnt = s_data[HDR_CNT_MSB:HDR_CNT_LSB];

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    frame_d      = frame_q;
    remaining_d  = remaining_q;
    frame_data_d = frame_data_q;
    done_d       = done_q;
    err_d        = err_q;
    col_load     = 1'b0;
    strobe_load  = 1'b0;

    unique case (state_q)
      HUNT: begin
        done_d = 1'b0;
        if (xfer && s_data == SYNC_WORD) state_d = HEADER;
      end
      HEADER: begin
        if (xfer) begin
          if (hdr_cnt == 16'd0) begin
            state_d = DONE;
          end else if (32'(hdr_col) >= NumColumns || 32'(hdr_frm) >= MaxFramesPerCol) begin
            state_d = ERR;
          end else begin
            col_d       = hdr_col;
            frame_d     = FRM_W'(hdr_frm);
            remaining_d = hdr_cnt;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          frame_data_d = s_data[FrameBitsPerRow-1:0];
          col_load     = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        // Strobe decoder is registered: load it here so the pulse lines up with STROBE.
        strobe_load = 1'b1;
        state_d     = STROBE;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        remaining_d = remaining_q - 16'd1;
        frame_d     = frame_q + FRM_W'(1);
        if (remaining_q == 16'd1)                       state_d = HEADER;
        else if (32'(frame_q) >= MaxFramesPerCol - 1)   state_d = ERR;
        else                                            state_d = DATA;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = HUNT;
      default: state_d = HUNT;
    endcase

    if (state_d == DONE) done_d = 1'b1;
    if (state_d == ERR)  err_d  = 1'b1;
  end

  // Registered outputs are decoded from the next state so they track the FSM without lag.
  assign s_ready_d = (state_d == HUNT) || (state_d == HEADER) || (state_d == DATA);
  assign col_clear = (state_d == HUNT) || (state_d == DONE) || (state_d == ERR);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      col_q        <= '0;
      frame_q      <= '0;
      remaining_q  <= '0;
      frame_data_q <= '0;
      s_ready_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      remaining_q  <= remaining_d;
      frame_data_q <= frame_data_d;
      s_ready_q    <= s_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  frame_strobe_decoder #(
    .WIDTH (MaxFramesPerCol),
    .IDX_W (FRM_W)
  ) u_strobe_dec (
    .clk      (CLK),
    .rst      (reset),
    .load     (strobe_load),
    .clear    (1'b1),
    .idx      (frame_q),
    .onehot_q (FrameStrobe)
  );

  frame_strobe_decoder #(
    .WIDTH (NumColumns),
    .IDX_W (8)
  ) u_col_dec (
    .clk      (CLK),
    .rst      (reset),
    .load     (col_load),
    .clear    (col_clear),
    .idx      (col_q),
    .onehot_q (ColSelect)
  );

  assign s_ready    = s_ready_q;
  assign FrameData  = frame_data_q;
  assign ConfigDone = done_q;
  assign ConfigErr  = err_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer: expected strobes are queued as
// data words are driven and compared when FrameStrobe pulses.
module tb_config_frame_writer;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [31:0] FrameStrobe;
  logic [15:0] ColSelect;
  logic        ConfigDone;
  logic        ConfigErr;

  config_frame_writer #(
    .FrameBitsPerRow (32),
    .MaxFramesPerCol (32),
    .NumColumns      (16)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ColSelect   (ColSelect),
    .ConfigDone  (ConfigDone),
    .ConfigErr   (ConfigErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [31:0] strobe;
    logic [15:0] col;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_pushed = 0;
  int unsigned strobe_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int unsigned col, input int unsigned frm,
                                      input int unsigned cnt);
    logic [7:0]  c;
    logic [4:0]  f;
    logic [15:0] n;
    c = 8'(col);
    f = 5'(frm);
    n = 16'(cnt);
    return {c, 3'b000, f, n};
  endfunction

  task automatic expect_strobe(input logic [31:0] d, input logic [31:0] s, input logic [15:0] c);
    exp_t e;
    e.data = d; e.strobe = s; e.col = c;
    sb.push_back(e);
    n_pushed++;
  endtask

  // Drive one word until accepted; optional random s_valid gaps.
  task automatic send(input logic [31:0] w, input bit gaps);
    int unsigned budget;
    bit done;
    bit v;
    budget = 0;
    done = 0;
    while (!done) begin
      @(negedge CLK);
      v = !gaps || ($urandom_range(1, 0) == 1);
      s_valid = v;
      s_data  = v ? w : 32'h0;
      if (v && s_ready) begin
        @(posedge CLK);
        #1 s_valid = 1'b0;
        done = 1;
      end else begin
        budget++;
        if (budget > 200) begin
          check_eq("send_timeout", 32'(budget), 32'd0);
          s_valid = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  // Strobe monitor: scoreboard compare plus pulse-width / data-stability checks.
  logic [31:0] prev_data = '0;
  logic [31:0] strobe_data = '0;
  logic        prev_strobe = 1'b0;

  always @(negedge CLK) begin
    if (reset) begin
      prev_strobe = 1'b0;
      prev_data   = FrameData;
    end else begin
      if (FrameStrobe != '0) begin
        exp_t e;
        strobe_cnt++;
        check_eq("strobe_onehot", 32'($onehot(FrameStrobe)), 32'd1);
        check_eq("strobe_width", 32'(prev_strobe), 32'd0);
        check_eq("data_setup", FrameData, prev_data);
        strobe_data = FrameData;
        if (sb.size() == 0) begin
          check_eq("unexp_strobe", FrameStrobe, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("strobe_val", FrameStrobe, e.strobe);
          check_eq("frame_data", FrameData, e.data);
          check_eq("col_select", 32'(ColSelect), 32'(e.col));
        end
      end else if (prev_strobe) begin
        check_eq("data_hold", FrameData, strobe_data);
      end
      prev_strobe = (FrameStrobe != '0);
      prev_data   = FrameData;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bit seen;
    int unsigned n;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_s_ready",  32'(s_ready), 32'd0);
    check_eq("rst_data",     FrameData, 32'd0);
    check_eq("rst_strobe",   FrameStrobe, 32'd0);
    check_eq("rst_col",      32'(ColSelect), 32'd0);
    check_eq("rst_done",     32'(ConfigDone), 32'd0);
    check_eq("rst_err",      32'(ConfigErr), 32'd0);
    reset = 1'b0;

    // Junk dropped, single frame write
    send(32'h0000_1234, 0);
    send(SYNC, 0);
    send(hdr(2, 0, 1), 0);
    expect_strobe(32'hDEAD_BEEF, 32'h0000_0001, 16'h0004);
    send(32'hDEAD_BEEF, 0);
    drain("t1_drain");
    check_eq("t1_err", 32'(ConfigErr), 32'd0);

    // Last two frames of a column
    send(hdr(0, 30, 2), 0);
    expect_strobe(32'h1111_0001, 32'h4000_0000, 16'h0001);
    send(32'h1111_0001, 0);
    expect_strobe(32'h1111_0002, 32'h8000_0000, 16'h0001);
    send(32'h1111_0002, 0);
    drain("t2_drain");
    check_eq("t2_err", 32'(ConfigErr), 32'd0);
    check_eq("t2_ready_hdr", 32'(s_ready), 32'd1);

    // Frame overrun
    send(hdr(0, 31, 2), 0);
    expect_strobe(32'h2222_0001, 32'h8000_0000, 16'h0001);
    send(32'h2222_0001, 0);
    drain("t3_drain");
    check_eq("t3_err", 32'(ConfigErr), 32'd1);
    check_eq("t3_col_clr", 32'(ColSelect), 32'd0);
    // In HUNT now: non-sync words are discarded, so no strobe may follow.
    send(32'h2222_0002, 0);
    send(hdr(1, 0, 1), 0);
    send(32'h2222_0003, 0);
    repeat (6) @(negedge CLK);
    check_eq("t3_no_strobe", 32'(strobe_cnt), 32'd4);

    // Illegal column, then recovery
    do_reset();
    send(SYNC, 0);
    send(hdr(16, 0, 1), 0);
    repeat (3) @(negedge CLK);
    check_eq("t4_err", 32'(ConfigErr), 32'd1);
    check_eq("t4_no_strobe", 32'(strobe_cnt), 32'd4);
    send(SYNC, 0);
    send(hdr(5, 3, 1), 0);
    expect_strobe(32'h5A5A_0003, 32'h0000_0008, 16'h0020);
    send(32'h5A5A_0003, 0);
    drain("t4_drain");

    // Eight frames with random s_valid gaps
    send(hdr(7, 8, 8), 1);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      expect_strobe(w, 32'h1 << (8 + i), 16'h0080);
      send(w, 1);
    end
    drain("t5_drain");
    check_eq("t5_count", 32'(strobe_cnt), 32'd13);

    // End of stream
    send(hdr(0, 0, 0), 0);
    repeat (2) @(negedge CLK);
    check_eq("t6_done", 32'(ConfigDone), 32'd1);
    check_eq("t6_ready", 32'(s_ready), 32'd0);
    check_eq("t6_col_clr", 32'(ColSelect), 32'd0);

    // Reset asserted during a strobe cycle
    do_reset();
    check_eq("t7_done_clr", 32'(ConfigDone), 32'd0);
    send(SYNC, 0);
    send(hdr(1, 0, 1), 0);
    expect_strobe(32'hCAFE_F00D, 32'h0000_0001, 16'h0002);
    send(32'hCAFE_F00D, 0);
    seen = 0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge CLK);
      seen = (FrameStrobe != '0);
      n++;
    end
    check_eq("t7_strobe_seen", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t7_strobe_zero", FrameStrobe, 32'd0);
    check_eq("t7_data_zero",   FrameData, 32'd0);
    check_eq("t7_col_zero",    32'(ColSelect), 32'd0);
    check_eq("t7_ready_zero",  32'(s_ready), 32'd0);
    check_eq("t7_err_zero",    32'(ConfigErr), 32'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (3) @(negedge CLK);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    check_eq("strobe_total", 32'(strobe_cnt), 32'(n_pushed));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
